// File: rtl/apb_uart_arbiter_if.sv
// APB bus bundle between the arbiter (master) and the UART register file (slave).
//   psel, penable, pwrite : APB control, driven by the master
//   paddr                 : APB address, driven by the master
//   pwdata                : APB write data, driven by the master
//   prdata                : APB read data, driven by the slave
//   pready                : transfer-complete strobe, driven by the slave
interface apb_uart_arbiter_if #(
    parameter int BITWIDTH = 8,
    parameter int ADDRW    = 2
);
    logic                psel;
    logic                penable;
    logic                pwrite;
    logic [ADDRW-1:0]    paddr;
    logic [BITWIDTH-1:0] pwdata;
    logic [BITWIDTH-1:0] prdata;
    logic                pready;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready
    );
endinterface

// File: rtl/apb_uart_arbiter.sv
// Two-port round-robin APB master arbiter in front of the UART register file.
// Each requester posts one read or write via req/done; the winner's command
// is captured at grant and run as a SETUP + ACCESS APB transfer, ending on
// pready or after TIMEOUT ACCESS cycles (err=1).
//   pclk, presetn          : clock, synchronous active-low reset
//   req*, we*, addr*, wdata*: requester commands (port 0 host, port 1 DMA)
//   done0, done1           : one-cycle completion pulse to the winner
//   rdata                  : data of the last completed read
//   err                    : timeout flag, valid with done*
//   busy                   : transfer in progress
//   apb                    : APB master bus
module apb_uart_arbiter #(
    parameter int BITWIDTH = 8,
    parameter int ADDRW    = 2,
    parameter int TIMEOUT  = 16
) (
    input  logic                pclk,
    input  logic                presetn,
    input  logic                req0,
    input  logic                req1,
    input  logic                we0,
    input  logic                we1,
    input  logic [ADDRW-1:0]    addr0,
    input  logic [ADDRW-1:0]    addr1,
    input  logic [BITWIDTH-1:0] wdata0,
    input  logic [BITWIDTH-1:0] wdata1,
    output logic                done0,
    output logic                done1,
    output logic [BITWIDTH-1:0] rdata,
    output logic                err,
    output logic                busy,
    apb_uart_arbiter_if.master  apb
);

    localparam int CNTW = $clog2(TIMEOUT + 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [CNTW-1:0]     cnt_r, cnt_s;
    logic                last_r, last_s;
    logic                pwrite_r, pwrite_s;
    logic [ADDRW-1:0]    paddr_r, paddr_s;
    logic [BITWIDTH-1:0] pwdata_r, pwdata_s;
    logic [BITWIDTH-1:0] rdata_r, rdata_s;
    logic                done0_r, done0_s;
    logic                done1_r, done1_s;
    logic                err_r, err_s;
    logic                psel_r, penable_r, busy_r;
    logic                elig0_s, elig1_s, grant_s;

    // Next-state, command capture and completion decode.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        last_s   = last_r;
        pwrite_s = pwrite_r;
        paddr_s  = paddr_r;
        pwdata_s = pwdata_r;
        rdata_s  = rdata_r;
        done0_s  = 1'b0;
        done1_s  = 1'b0;
        err_s    = 1'b0;

        // A port whose done is high right now is finishing, not asking again.
        elig0_s = req0 & ~done0_r;
        elig1_s = req1 & ~done1_r;
        if (elig0_s && elig1_s) begin
            grant_s = ~last_r;
        end else if (elig1_s) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end

        case (state_r)
            ST_IDLE: begin
                if (elig0_s || elig1_s) begin
                    state_s  = ST_SETUP;
                    last_s   = grant_s;
                    pwrite_s = grant_s ? we1    : we0;
                    paddr_s  = grant_s ? addr1  : addr0;
                    pwdata_s = grant_s ? wdata1 : wdata0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_s = ST_ACCESS;
                cnt_s   = '0;
            end
            ST_ACCESS: begin
                // last_r names the current winner from grant onwards.
                if (apb.pready) begin
                    state_s = ST_IDLE;
                    done0_s = ~last_r;
                    done1_s = last_r;
                    if (!pwrite_r) begin
                        rdata_s = apb.prdata;
                    end else begin
                        rdata_s = rdata_r;
                    end
                end else if (cnt_r == CNT_LAST) begin
                    state_s = ST_IDLE;
                    done0_s = ~last_r;
                    done1_s = last_r;
                    err_s   = 1'b1;
                end else begin
                    cnt_s = cnt_r + 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; bus control is registered from next state.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            last_r    <= 1'b1;
            pwrite_r  <= 1'b0;
            paddr_r   <= '0;
            pwdata_r  <= '0;
            rdata_r   <= '0;
            done0_r   <= 1'b0;
            done1_r   <= 1'b0;
            err_r     <= 1'b0;
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            last_r    <= last_s;
            pwrite_r  <= pwrite_s;
            paddr_r   <= paddr_s;
            pwdata_r  <= pwdata_s;
            rdata_r   <= rdata_s;
            done0_r   <= done0_s;
            done1_r   <= done1_s;
            err_r     <= err_s;
            psel_r    <= (state_s != ST_IDLE);
            penable_r <= (state_s == ST_ACCESS);
            busy_r    <= (state_s != ST_IDLE);
        end
    end

    assign apb.psel    = psel_r;
    assign apb.penable = penable_r;
    assign apb.pwrite  = pwrite_r;
    assign apb.paddr   = paddr_r;
    assign apb.pwdata  = pwdata_r;
    assign done0       = done0_r;
    assign done1       = done1_r;
    assign err         = err_r;
    assign rdata       = rdata_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_apb_uart_arbiter.sv
// Self-checking bench for apb_uart_arbiter: directed scenarios followed by
// randomized request patterns, checked against a transaction-level model.
module tb_apb_uart_arbiter;

    localparam int BW      = 8;
    localparam int ADDRW   = 2;
    localparam int TIMEOUT = 16;

    logic             pclk = 1'b0;
    logic             presetn;
    logic             req0, req1, we0, we1;
    logic [ADDRW-1:0] addr0, addr1;
    logic [BW-1:0]    wdata0, wdata1;
    logic             done0, done1, err, busy;
    logic [BW-1:0]    rdata;

    int tests = 0;
    int fails = 0;

    // Model state: round-robin history and last read value.
    bit            m_last;
    logic [BW-1:0] m_rdata;
    int            md;

    apb_uart_arbiter_if #(.BITWIDTH(BW), .ADDRW(ADDRW)) bus ();

    apb_uart_arbiter #(.BITWIDTH(BW), .ADDRW(ADDRW), .TIMEOUT(TIMEOUT)) dut (
        .pclk(pclk), .presetn(presetn),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .done0(done0), .done1(done1), .rdata(rdata), .err(err), .busy(busy),
        .apb(bus)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Arbitration rule: single eligible wins; a tie goes to the port other than last.
    function automatic bit pick(input bit e0, input bit e1, input bit last);
        if (e0 && e1) return !last;
        else if (e1) return 1'b1;
        else return 1'b0;
    endfunction

    task automatic idle_step();
        @(posedge pclk); #1;
        chk("idle_psel", bus.psel, 1'b0);
        chk("idle_done", {done0, done1, err}, 3'b000);
    endtask

    // One full transfer; the expected winner's command is sampled before the grant edge.
    task automatic xfer(input int waits, input bit exp_port, input bit drop_mid, input int fix_pr);
        logic             cw;
        logic [ADDRW-1:0] ca;
        logic [BW-1:0]    cd;
        logic [BW-1:0]    pr;
        int               acc;
        bit               to_exp;
        cw = exp_port ? we1 : we0;
        ca = exp_port ? addr1 : addr0;
        cd = exp_port ? wdata1 : wdata0;
        to_exp = (waits >= TIMEOUT);
        @(posedge pclk); #1;
        chk("setup_psel", bus.psel, 1'b1);
        chk("setup_penable", bus.penable, 1'b0);
        chk("setup_paddr", bus.paddr, ca);
        chk("setup_pwdata", bus.pwdata, cd);
        chk("setup_pwrite", bus.pwrite, cw);
        chk("setup_busy", busy, 1'b1);
        chk("setup_no_done", {done0, done1}, 2'b00);
        bus.pready = 1'b0;
        acc = 0;
        @(posedge pclk); #1;
        while (bus.penable === 1'b1 && acc < 64) begin
            acc++;
            chk("access_psel", bus.psel, 1'b1);
            chk("access_paddr", bus.paddr, ca);
            chk("access_pwdata", bus.pwdata, cd);
            chk("access_pwrite", bus.pwrite, cw);
            chk("access_no_done", {done0, done1, err}, 3'b000);
            if (drop_mid && acc == 1) begin
                if (exp_port) begin
                    req1 = 1'b0; addr1 = ~addr1; wdata1 = ~wdata1; we1 = ~we1;
                end else begin
                    req0 = 1'b0; addr0 = ~addr0; wdata0 = ~wdata0; we0 = ~we0;
                end
            end
            pr = (fix_pr >= 0) ? BW'(fix_pr) : BW'($urandom);
            bus.prdata = pr;
            bus.pready = (acc - 1 == waits);
            if (bus.pready && !cw) m_rdata = pr;
            @(posedge pclk); #1;
        end
        bus.pready = 1'b0;
        chk("access_cycles", acc, to_exp ? TIMEOUT : waits + 1);
        chk("done0", done0, !exp_port);
        chk("done1", done1, exp_port);
        chk("err", err, to_exp);
        chk("rdata", rdata, m_rdata);
        chk("end_psel", bus.psel, 1'b0);
        chk("end_penable", bus.penable, 1'b0);
        chk("end_busy", busy, 1'b0);
        m_last = exp_port;
    endtask

    initial begin
        bit e0, e1, w;
        int waits;
        presetn = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        bus.pready = 1'b0; bus.prdata = '0;
        m_last = 1'b1; m_rdata = '0; md = -1;
        repeat (2) @(posedge pclk);
        #1;
        chk("rst_psel", bus.psel, 1'b0);
        chk("rst_penable", bus.penable, 1'b0);
        chk("rst_pwrite", bus.pwrite, 1'b0);
        chk("rst_paddr", bus.paddr, 2'd0);
        chk("rst_pwdata", bus.pwdata, 8'h00);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_flags", {done0, done1, err, busy}, 4'b0000);
        presetn = 1'b1;

        // Zero-wait write from port 0.
        req0 = 1'b1; we0 = 1'b1; addr0 = 2'd0; wdata0 = 8'h1A;
        xfer(0, 1'b0, 1'b0, -1);
        req0 = 1'b0;
        idle_step();

        // Read from port 1 with two wait states.
        req1 = 1'b1; we1 = 1'b0; addr1 = 2'd2;
        xfer(2, 1'b1, 1'b0, 32'h5C);
        chk("read_rdata_5c", rdata, 8'h5C);
        req1 = 1'b0;
        idle_step();

        // Timeout: slave never ready; rdata must keep 0x5C.
        req0 = 1'b1; we0 = 1'b0; addr0 = 2'd3;
        xfer(TIMEOUT, 1'b0, 1'b0, -1);
        req0 = 1'b0;
        idle_step();

        // Requester inputs disturbed mid-transfer.
        req0 = 1'b1; we0 = 1'b1; addr0 = 2'd1; wdata0 = 8'hA5;
        xfer(2, 1'b0, 1'b1, -1);
        idle_step();

        // Reset during ACCESS.
        req0 = 1'b1; we0 = 1'b1; addr0 = 2'd2; wdata0 = 8'h77;
        @(posedge pclk); #1;
        chk("rm_setup", bus.psel, 1'b1);
        @(posedge pclk); #1;
        chk("rm_access", bus.penable, 1'b1);
        presetn = 1'b0; req0 = 1'b0;
        @(posedge pclk); #1;
        chk("rm_psel", bus.psel, 1'b0);
        chk("rm_penable", bus.penable, 1'b0);
        chk("rm_pwrite", bus.pwrite, 1'b0);
        chk("rm_paddr", bus.paddr, 2'd0);
        chk("rm_pwdata", bus.pwdata, 8'h00);
        chk("rm_rdata", rdata, 8'h00);
        chk("rm_flags", {done0, done1, err, busy}, 4'b0000);
        presetn = 1'b1;
        m_last = 1'b1; m_rdata = '0;

        // Both held after reset: grants alternate 0, 1, 0, 1.
        req0 = 1'b1; we0 = 1'b1; addr0 = 2'd1; wdata0 = 8'h33;
        req1 = 1'b1; we1 = 1'b0; addr1 = 2'd3; wdata1 = 8'hC4;
        xfer(0, 1'b0, 1'b0, -1);
        xfer(1, 1'b1, 1'b0, -1);
        xfer(0, 1'b0, 1'b0, -1);
        xfer(2, 1'b1, 1'b0, -1);
        md = 1;

        // Randomized traffic; a pending loser keeps its request and command.
        for (int it = 0; it < 40; it++) begin
            if (!(req0 && md != 0)) begin
                req0 = 1'($urandom_range(0, 1)); we0 = 1'($urandom_range(0, 1));
                addr0 = ADDRW'($urandom); wdata0 = BW'($urandom);
            end
            if (!(req1 && md != 1)) begin
                req1 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
                addr1 = ADDRW'($urandom); wdata1 = BW'($urandom);
            end
            if (!req0 && !req1) req0 = 1'b1;
            e0 = req0 && (md != 0);
            e1 = req1 && (md != 1);
            if (!e0 && !e1) begin
                idle_step();
                md = -1;
                e0 = req0;
                e1 = req1;
            end
            w = pick(e0, e1, m_last);
            waits = ($urandom_range(0, 9) == 0) ? TIMEOUT : int'($urandom_range(0, 3));
            xfer(waits, w, 1'b0, -1);
            md = w ? 1 : 0;
        end

        req0 = 1'b0; req1 = 1'b0;
        idle_step();
        idle_step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/apb_uart_arbiter.md
# apb_uart_arbiter

Two-port APB master arbiter that shares the UART register-file slave between two requesters (port 0: host/CPU side, port 1: DMA/sequencer side). Each requester posts a single read or write through a req/done handshake. The block arbitrates round-robin, runs a standard two-phase APB transfer (SETUP, then ACCESS until `pready`), and returns read data and a timeout error flag to the winner. It sits between the requesters and the slave's `psel`/`penable`/`pwrite`/`P_ADDR`/`PW_DATA`/`Pr_data`/`P_READY` pins.

## Interface

Parameters:
- `BITWIDTH`, default 8: data width of the APB bus and requester data.
- `ADDRW`, default 2: APB address width.
- `TIMEOUT`, default 16: maximum ACCESS cycles waiting for `pready`; legal range ≥ 1.

Ports:
- `pclk` in 1: single clock; all logic on rising edge.
- `presetn` in 1: reset; synchronous, active-low.
- `req0`, `req1` in 1: transfer request. Held until the matching `done` is seen.
- `we0`, `we1` in 1: 1 = write, 0 = read.
- `addr0`, `addr1` in ADDRW: register address.
- `wdata0`, `wdata1` in BITWIDTH: write data.
- `done0`, `done1` out 1: one-cycle completion pulse to the granted requester.
- `rdata` out BITWIDTH: read data of the last completed read; shared by both ports.
- `err` out 1: valid with `done*`; 1 = transfer ended by timeout.
- `busy` out 1: 1 whenever state ≠ IDLE.
- `psel`, `penable`, `pwrite` out 1: APB control.
- `paddr` out ADDRW: APB address.
- `pwdata` out BITWIDTH: APB write data.
- `prdata` in BITWIDTH: APB read data.
- `pready` in 1: APB ready from slave.

## Operation

- FSM states: IDLE, SETUP, ACCESS.
- **IDLE.** Bus outputs are `psel=0` and `penable=0`. Eligible requester n means `reqn=1` and `donen=0` in that cycle; this masks the requester that is just completing.
  - One eligible requester: it is granted.
  - Both eligible: the port not equal to `last` wins.
  - On grant: capture `we`/`addr`/`wdata` of the winner into `pwrite`/`paddr`/`pwdata`, set `last` to the winner, and go to SETUP.
- **SETUP.** `psel=1`, `penable=0`; unconditionally go to ACCESS. Clear the timeout counter.
- **ACCESS.** `psel=1`, `penable=1`; `pwrite`/`paddr`/`pwdata` stable.
  - If `pready=1`:
    - Register `done<winner>=1` and `err=0`.
    - If a read, register `rdata<=prdata`.
    - Go to IDLE.
  - Else, if the counter equals TIMEOUT-1: register `done<winner>=1` and `err=1`, leave `rdata` unchanged, and go to IDLE.
  - Else: increment the counter.
- The counter width is the bit width needed to hold TIMEOUT. It never exceeds TIMEOUT-1.
- Captured command is frozen from grant to completion. Requester inputs changing or `req` dropping mid-transfer have no effect; the transfer completes and `done` still pulses.
- `done0`/`done1` are mutually exclusive, high for exactly one cycle, and only on completion.
- `err` is high only in the `done` cycle; otherwise 0.
- `rdata` holds its value between reads. Writes do not alter it.
- `pwrite`/`paddr`/`pwdata` hold their last values while in IDLE.

## Timing

- Reset (`presetn=0` at a rising edge), the next cycle shows:
  - state IDLE, `last=1` (port 0 wins the first tie);
  - `psel=0`, `penable=0`, `pwrite=0`, `paddr=0`, `pwdata=0`;
  - `rdata=0`, `done0=done1=0`, `err=0`, `busy=0`.
- Reset mid-transfer abandons it at once: no `done` and no `err`.
- Zero-wait transfer, with `req` seen in IDLE at edge E:
  - SETUP in cycle E+1;
  - ACCESS in cycle E+2;
  - `done` plus IDLE in cycle E+3.
- Each wait cycle (`pready=0` in ACCESS) adds one cycle.
- Timeout: `done`/`err` arrive TIMEOUT ACCESS cycles after ACCESS entry.
- At least one IDLE cycle separates consecutive transfers. Peak throughput is one transfer per 3 cycles.
- A requester must deassert `req` in the cycle its `done` is high, or raise a new request only from the following cycle.

## Test plan

- Reset then single write, port 0: `addr0=0`, `wdata0=0x1A`, `we0=1`, `pready=1`.
  - Required: `psel` high 2 cycles, `penable` high in cycle 2, `paddr=0`, `pwdata=0x1A`.
  - Required: `done0` pulses 3 cycles after request; `err=0`.
- Read with 2 wait states, port 1: `addr1=2`, `prdata=0x5C`, `pready` low 2 ACCESS cycles.
  - Required: ACCESS lasts 3 cycles, `rdata=0x5C`, `done1=1`, `err=0`, `done0=0`.
- Simultaneous requests after reset, both held and re-requested:
  - Required grant order 0, 1, 0, 1.
  - Required: exactly one IDLE cycle between transfers; no double grant to the completing port.
- Timeout: `TIMEOUT=16`, `pready` tied 0.
  - Required: 16 ACCESS cycles, then `done0=1` with `err=1`, `rdata` unchanged, bus returns to `psel=0`.
- Mid-transfer disturbance:
  - `req0` dropped and `addr0`/`wdata0` changed during ACCESS. Required: `paddr`/`pwdata` unchanged and `done0` still pulses.
  - Separately, `presetn=0` during ACCESS. Required: next cycle shows all outputs at reset values and no `done`.
